// File: rtl/conv_pkg.sv
// Shared definitions for the conv datapath: FSM state encoding and the default
// word width common to the conv FIFO and its write-side arbiter.
package conv_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_e;

    localparam int CONV_WIDTH = 9;

endpackage : conv_pkg

// File: rtl/conv_rr_pick.sv
// Round-robin pick: first set request at or after rr_ptr_i, wrapping modulo NUM_REQ.
// Purely combinational; shared with the conv read-side schedulers.
module conv_rr_pick #(
    parameter int NUM_REQ  = 4,
    parameter int REQ_BITS = 2
) (
    input  logic [NUM_REQ-1:0]  req_i,
    input  logic [REQ_BITS-1:0] rr_ptr_i,
    output logic [REQ_BITS-1:0] sel_o,
    output logic                any_req_o
);

    logic [2*NUM_REQ-1:0] req_dbl;
    logic [NUM_REQ-1:0]   req_rot;
    logic [REQ_BITS-1:0]  rot_idx;

    // Bit k of req_rot is requester (rr_ptr_i + k) mod NUM_REQ.
    assign req_dbl = {req_i, req_i};
    assign req_rot = req_dbl[{1'b0, rr_ptr_i} +: NUM_REQ];

    // NOTE: the default before the loop keeps rot_idx assigned on every path, so no latch.
    always_comb begin
        rot_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                rot_idx = REQ_BITS'(i);
            end
        end
    end

    assign sel_o     = rr_ptr_i + rot_idx;
    assign any_req_o = |req_i;

endmodule : conv_rr_pick

// File: rtl/conv_fifo_wr_arb.sv
// Round-robin write-port arbiter: NUM_REQ producers share one conv FIFO write port,
// one grantee at a time for bursts of up to BURST_LEN words, stalled by fifo_full.
module conv_fifo_wr_arb
    import conv_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int REQ_BITS  = 2,
    parameter int WIDTH     = CONV_WIDTH,
    parameter int BURST_LEN = 16,
    parameter int CNT_BITS  = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] data_in,
    input  logic                     fifo_full,
    output logic [NUM_REQ-1:0]       grant,
    output logic [NUM_REQ-1:0]       ack,
    output logic                     fifo_w_en,
    output logic [WIDTH-1:0]         fifo_data_w,
    output logic [REQ_BITS-1:0]      owner,
    output logic                     busy
);

    state_e               state_q;
    logic [NUM_REQ-1:0]   grant_q;
    logic [REQ_BITS-1:0]  owner_q;
    logic [REQ_BITS-1:0]  rr_ptr_q;
    logic [CNT_BITS-1:0]  beat_cnt_q;
    logic                 busy_q;

    logic [REQ_BITS-1:0]  pick_sel;
    logic                 pick_any;
    logic                 owner_req;
    logic                 beat;
    logic                 last_beat;

    conv_rr_pick #(
        .NUM_REQ  (NUM_REQ),
        .REQ_BITS (REQ_BITS)
    ) u_pick (
        .req_i     (req),
        .rr_ptr_i  (rr_ptr_q),
        .sel_o     (pick_sel),
        .any_req_o (pick_any)
    );

    // Reset gates the beat so a mid-burst reset never writes on its own cycle.
    assign owner_req = req[owner_q];
    assign beat      = (state_q == ST_BURST) && !reset && grant_q[owner_q]
                       && owner_req && !fifo_full;
    assign last_beat = beat && (beat_cnt_q == CNT_BITS'(BURST_LEN - 1));

    always_comb begin
        ack         = '0;
        fifo_data_w = '0;
        if (beat) begin
            ack[owner_q] = 1'b1;
            fifo_data_w  = data_in[owner_q*WIDTH +: WIDTH];
        end
    end

    assign fifo_w_en = beat;

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pick_any) begin
                        state_q    <= ST_BURST;
                        grant_q    <= NUM_REQ'(1) << pick_sel;
                        owner_q    <= pick_sel;
                        busy_q     <= 1'b1;
                        beat_cnt_q <= '0;
                    end
                end
                ST_BURST: begin
                    if (beat) begin
                        beat_cnt_q <= beat_cnt_q + 1'b1;
                    end
                    // Release takes priority over a stall: a dropped req ends the burst even when full.
                    if (!owner_req || last_beat) begin
                        state_q  <= ST_IDLE;
                        grant_q  <= '0;
                        busy_q   <= 1'b0;
                        rr_ptr_q <= owner_q + 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign grant = grant_q;
    assign owner = owner_q;
    assign busy  = busy_q;

endmodule : conv_fifo_wr_arb

// File: tb/tb_conv_fifo_wr_arb.sv
// Bench for conv_fifo_wr_arb: a word-counting arbiter model checked every cycle,
// plus directed scenarios pinned by hand-computed write logs.
module tb_conv_fifo_wr_arb;

    localparam int NUM_REQ   = 4;
    localparam int REQ_BITS  = 2;
    localparam int WIDTH     = 9;
    localparam int BURST_LEN = 16;
    localparam int CNT_BITS  = 5;

    logic                     clk = 1'b0;
    logic                     reset;
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*WIDTH-1:0] data_in;
    logic                     fifo_full;
    logic [NUM_REQ-1:0]       grant;
    logic [NUM_REQ-1:0]       ack;
    logic                     fifo_w_en;
    logic [WIDTH-1:0]         fifo_data_w;
    logic [REQ_BITS-1:0]      owner;
    logic                     busy;

    conv_fifo_wr_arb #(
        .NUM_REQ   (NUM_REQ),
        .REQ_BITS  (REQ_BITS),
        .WIDTH     (WIDTH),
        .BURST_LEN (BURST_LEN),
        .CNT_BITS  (CNT_BITS)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .data_in     (data_in),
        .fifo_full   (fifo_full),
        .grant       (grant),
        .ack         (ack),
        .fifo_w_en   (fifo_w_en),
        .fifo_data_w (fifo_data_w),
        .owner       (owner),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Producers: requester i sends words i*128 + seq[i] and holds req while rem[i] > 0.
    int               rem [NUM_REQ];
    int               seq [NUM_REQ];
    logic [NUM_REQ-1:0] ack_seen;

    int   wr_own [$];
    int   wr_dat [$];
    int   wr_cyc [$];
    int   cyc = 0;
    bit   chk_en = 1'b0;

    // Arbiter model: tracks who holds the port and how many words it has written.
    bit   m_busy  = 1'b0;
    int   m_owner = 0;
    int   m_rr    = 0;
    int   m_words = 0;

    function automatic int first_from(input logic [NUM_REQ-1:0] r, input int p);
        for (int k = 0; k < NUM_REQ; k++) begin
            if (r[(p + k) % NUM_REQ]) return (p + k) % NUM_REQ;
        end
        return 0;
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset) begin
            m_busy  <= 1'b0;
            m_owner <= 0;
            m_rr    <= 0;
            m_words <= 0;
        end else if (!m_busy) begin
            if (req != '0) begin
                m_busy  <= 1'b1;
                m_owner <= first_from(req, m_rr);
                m_words <= 0;
            end
        end else if (!req[m_owner]) begin
            m_busy <= 1'b0;
            m_rr   <= (m_owner + 1) % NUM_REQ;
        end else if (!fifo_full) begin
            m_words <= m_words + 1;
            if (m_words + 1 == BURST_LEN) begin
                m_busy <= 1'b0;
                m_rr   <= (m_owner + 1) % NUM_REQ;
            end
        end
    end

    always @(negedge clk) begin
        bit                 e_beat;
        logic [NUM_REQ-1:0] e_grant;
        logic [WIDTH-1:0]   e_data;
        ack_seen = ack;
        if (chk_en) begin
            e_beat  = m_busy && !reset && req[m_owner] && !fifo_full;
            e_grant = m_busy ? (NUM_REQ'(1) << m_owner) : '0;
            e_data  = e_beat ? data_in[m_owner*WIDTH +: WIDTH] : '0;
            check("grant", 32'(grant), 32'(e_grant));
            check("busy", 32'(busy), 32'(m_busy));
            check("owner", 32'(owner), 32'(m_owner));
            check("ack", 32'(ack), e_beat ? 32'(1 << m_owner) : 32'd0);
            check("fifo_w_en", 32'(fifo_w_en), 32'(e_beat));
            check("fifo_data_w", 32'(fifo_data_w), 32'(e_data));
        end
        if (fifo_w_en) begin
            wr_own.push_back(int'(owner));
            wr_dat.push_back(int'(fifo_data_w));
            wr_cyc.push_back(cyc);
        end
    end

    task automatic drive();
        for (int i = 0; i < NUM_REQ; i++) begin
            req[i] = (rem[i] > 0);
            data_in[i*WIDTH +: WIDTH] = WIDTH'(i * 128 + seq[i]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (ack_seen[i]) begin
                seq[i]++;
                rem[i]--;
            end
        end
        drive();
    endtask

    function automatic bit rem_any();
        for (int i = 0; i < NUM_REQ; i++) if (rem[i] > 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic start_test();
        for (int i = 0; i < NUM_REQ; i++) begin
            rem[i] = 0;
            seq[i] = 0;
        end
        fifo_full = 1'b0;
        reset     = 1'b1;
        drive();
        step();
        step();
        reset = 1'b0;
        wr_own.delete();
        wr_dat.delete();
        wr_cyc.delete();
    endtask

    task automatic wait_writes(input string name, input int n);
        int g = 0;
        while (wr_dat.size() < n && g < 300) begin
            step();
            g++;
        end
        check({name, "_wait"}, 32'(wr_dat.size() >= n), 32'd1);
    endtask

    task automatic run_idle(input string name);
        int g = 0;
        while ((rem_any() || m_busy) && g < 600) begin
            step();
            g++;
        end
        check({name, "_done"}, 32'(g < 600), 32'd1);
    endtask

    initial begin
        int c0;
        reset     = 1'b1;
        fifo_full = 1'b0;
        req       = '0;
        data_in   = '0;
        ack_seen  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rem[i] = 0;
            seq[i] = 0;
        end
        @(posedge clk);
        #1;
        chk_en = 1'b1;

        // Reset state
        start_test();
        @(negedge clk);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_owner", 32'(owner), 32'd0);
        check("rst_wen", 32'(fifo_w_en), 32'd0);

        // Single requester: 16 words, bubble, then 4 more
        rem[0] = 20;
        drive();
        c0 = cyc;
        run_idle("single");
        check("single_count", 32'(wr_dat.size()), 32'd20);
        for (int k = 0; k < 20; k++) check("single_data", 32'(wr_dat[k]), 32'(k));
        check("single_latency", 32'(wr_cyc[0] - c0), 32'd1);
        check("single_burst_span", 32'(wr_cyc[15] - wr_cyc[0]), 32'd15);
        check("single_bubble", 32'(wr_cyc[16] - wr_cyc[15]), 32'd2);

        // Round-robin fairness: all requesting, order 0,1,2,3,0
        start_test();
        rem[0] = 32;
        rem[1] = 16;
        rem[2] = 16;
        rem[3] = 16;
        drive();
        run_idle("rr");
        check("rr_count", 32'(wr_dat.size()), 32'd80);
        check("rr_own0", 32'(wr_own[0]), 32'd0);
        check("rr_own1", 32'(wr_own[16]), 32'd1);
        check("rr_own2", 32'(wr_own[32]), 32'd2);
        check("rr_own3", 32'(wr_own[48]), 32'd3);
        check("rr_own4", 32'(wr_own[64]), 32'd0);
        check("rr_data4", 32'(wr_dat[64]), 32'd16);
        check("rr_span3", 32'(wr_cyc[63] - wr_cyc[48]), 32'd15);

        // Back-pressure on owner 2 after 5 beats, for 7 cycles
        start_test();
        rem[2] = 20;
        drive();
        wait_writes("bp", 5);
        fifo_full = 1'b1;
        repeat (7) step();
        check("bp_stalled", 32'(wr_dat.size()), 32'd5);
        fifo_full = 1'b0;
        run_idle("bp");
        check("bp_count", 32'(wr_dat.size()), 32'd20);
        check("bp_gap", 32'(wr_cyc[5] - wr_cyc[4]), 32'd8);
        check("bp_resume", 32'(wr_cyc[15] - wr_cyc[5]), 32'd10);
        check("bp_bubble", 32'(wr_cyc[16] - wr_cyc[15]), 32'd2);
        check("bp_data15", 32'(wr_dat[15]), 32'd271);

        // Early release by requester 1; rr_ptr=2 must favour 3 over 0
        start_test();
        rem[1] = 3;
        rem[3] = 2;
        drive();
        wait_writes("rel", 1);
        rem[0] = 2;
        drive();
        run_idle("rel");
        check("rel_count", 32'(wr_dat.size()), 32'd7);
        check("rel_own2", 32'(wr_own[2]), 32'd1);
        check("rel_own3", 32'(wr_own[3]), 32'd3);
        check("rel_own5", 32'(wr_own[5]), 32'd0);
        check("rel_data", 32'(wr_dat[3]), 32'd384);
        check("rel_gap", 32'(wr_cyc[3] - wr_cyc[2]), 32'd3);

        // Reset mid-burst at beat 8 of owner 0
        start_test();
        rem[0] = 20;
        rem[2] = 2;
        drive();
        wait_writes("mrst", 8);
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        check("mrst_grant", 32'(grant), 32'd0);
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_owner", 32'(owner), 32'd0);
        check("mrst_nowrite", 32'(wr_dat.size()), 32'd8);
        run_idle("mrst");
        check("mrst_own8", 32'(wr_own[8]), 32'd0);
        check("mrst_data8", 32'(wr_dat[8]), 32'd8);
        check("mrst_gap", 32'(wr_cyc[8] - wr_cyc[7]), 32'd3);

        // Full and release in the same cycle
        start_test();
        rem[1] = 4;
        drive();
        wait_writes("fr", 4);
        fifo_full = 1'b1;
        rem[0] = 1;
        rem[2] = 1;
        drive();
        step();
        fifo_full = 1'b0;
        check("fr_nowrite", 32'(wr_dat.size()), 32'd4);
        run_idle("fr");
        check("fr_count", 32'(wr_dat.size()), 32'd6);
        check("fr_own4", 32'(wr_own[4]), 32'd2);
        check("fr_own5", 32'(wr_own[5]), 32'd0);
        check("fr_data4", 32'(wr_dat[4]), 32'd256);
        check("fr_gap", 32'(wr_cyc[4] - wr_cyc[3]), 32'd3);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule : tb_conv_fifo_wr_arb
